// File: rtl/perf_counter_sched.sv
// Profiling front end: a command-driven run window gates event pulses into a bank of
// split-half counters, then the frozen bank is streamed out over a valid/ready readout port.
module perf_counter_sched #(
  parameter int NUM_EVENTS = 4,
  parameter int WINDOW_W   = 32,
  parameter int HALF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WINDOW_W-1:0]   cmd_window,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic                  running,
  output logic                  window_done,
  output logic                  cmd_err,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [3:0]            rd_idx,
  output logic [63:0]           rd_data,
  output logic                  rd_ovf,
  output logic                  rd_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP} state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [3:0] LAST_IDX = 4'(NUM_EVENTS - 1);

  state_t                r_state;
  state_t                w_next;
  logic [WINDOW_W-1:0]   r_wcnt;
  logic [HALF_W-1:0]     r_lo [NUM_EVENTS];
  logic [HALF_W-1:0]     r_hi [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] r_ovf;
  logic [3:0]            r_idx;
  logic                  r_cmdErr;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_clear;
  logic                  w_last;
  logic [HALF_W-1:0]     w_selLo;
  logic [HALF_W-1:0]     w_selHi;
  logic                  w_selOvf;

  // Gating with rst keeps cmd_ready low while reset is held.
  assign cmd_ready = rst & (r_state != S_DUMP);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_clear   = (r_state == S_IDLE) & w_accept & (cmd_op == OP_CLEAR);
  assign w_last    = (r_idx == LAST_IDX);
  assign cmd_err   = r_cmdErr;
  assign rd_idx    = r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    running     = 1'b0;
    window_done = 1'b0;
    rd_valid    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && cmd_op == OP_START) w_next = S_RUN;
        if (w_accept && cmd_op == OP_STOP)  w_illegal = 1'b1;
      end
      S_RUN: begin
        running     = 1'b1;
        // wcnt==0 in RUN means an unbounded window; bounded runs leave RUN at wcnt==1.
        window_done = (r_wcnt == WINDOW_W'(1));
        if (window_done || (w_accept && cmd_op == OP_STOP)) w_next = S_DUMP;
        if (w_accept && (cmd_op == OP_START || cmd_op == OP_CLEAR)) w_illegal = 1'b1;
      end
      S_DUMP: begin
        rd_valid = 1'b1;
        if (rd_ready && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt   <= '0;
      r_idx    <= 4'd0;
      r_cmdErr <= 1'b0;
      r_ovf    <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        r_lo[i] <= '0;
        r_hi[i] <= '0;
      end
    end else begin
      r_cmdErr <= w_illegal;
      if (r_state == S_IDLE && w_accept && cmd_op == OP_START)
        r_wcnt <= cmd_window;
      else if (r_state == S_RUN && r_wcnt != '0)
        r_wcnt <= r_wcnt - WINDOW_W'(1);
      if (r_state == S_DUMP && rd_ready)
        r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
      // Lower half carries into upper; wrapping the full counter sets the sticky flag.
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (w_clear) begin
          r_lo[i]  <= '0;
          r_hi[i]  <= '0;
          r_ovf[i] <= 1'b0;
        end else if (r_state == S_RUN && event_in[i]) begin
          r_lo[i] <= r_lo[i] + HALF_W'(1);
          if (r_lo[i] == '1) begin
            r_hi[i] <= r_hi[i] + HALF_W'(1);
            if (r_hi[i] == '1) r_ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_selLo  = '0;
    w_selHi  = '0;
    w_selOvf = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (r_idx == 4'(i)) begin
        w_selLo  = r_lo[i];
        w_selHi  = r_hi[i];
        w_selOvf = r_ovf[i];
      end
    end
  end

  // Each half is zero-extended into its own 32-bit slot of the readout word.
  assign rd_data = rd_valid ? {32'(w_selHi), 32'(w_selLo)} : 64'd0;
  assign rd_ovf  = rd_valid & w_selOvf;
  assign rd_last = rd_valid & w_last;

endmodule

// File: doc/perf_counter_sched.md
Name: perf_counter_sched

Overview:
- Controller and scheduler for a bank of 64-bit event counters built from split 32-bit lower/upper halves with carry.
- Accepts START/STOP/CLEAR commands over a valid/ready port and gates per-channel event pulses into the bank during a run window.
- On stop or window expiry, freezes the bank and streams every counter out over a valid/ready readout port.
- Sits beside accelerator datapaths as the profiling front end for cycle and stall statistics.

Parameters:
NUM_EVENTS, 4, number of event channels and counters (1..16)
WINDOW_W, 32, width of the run-window length field

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 CLEAR
cmd_window  input  WINDOW_W  run length in cycles for START; 0 = unbounded
event_in  input  NUM_EVENTS  per-channel increment request, one per cycle max
running  output  1  high while in RUN
window_done  output  1  one-cycle pulse on window expiry
cmd_err  output  1  one-cycle pulse when an accepted command is illegal in the current state
rd_valid  output  1  readout word valid
rd_ready  input  1  consumer ready
rd_idx  output  4  channel index of rd_data
rd_data  output  64  counter value {upper,lower}
rd_ovf  output  1  sticky wrap flag of channel rd_idx
rd_last  output  1  high with the word for channel NUM_EVENTS-1

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, ovf flags, window count and rd_idx = 0; every output 0. Reset mid-RUN or mid-DUMP aborts immediately, with no readout.
- States:
  - IDLE: cmd_ready=1. START with window W loads wcnt=W and enters RUN next cycle. CLEAR zeroes all counters and ovf flags next cycle and stays IDLE. STOP pulses cmd_err and stays IDLE. NOP has no effect.
  - RUN: running=1, cmd_ready=1. Each cycle, counter i increments when event_in[i]=1.
    - If W!=0, wcnt decrements each RUN cycle. The cycle with wcnt==1 is the last counting cycle; the next state is DUMP and window_done pulses in that cycle. Exactly W counting cycles occur.
    - An accepted STOP counts its own cycle's events, then enters DUMP next cycle.
    - START or CLEAR in RUN is consumed without effect and pulses cmd_err.
    - STOP in the same cycle as window expiry: one DUMP entry, and window_done still pulses.
  - DUMP: cmd_ready=0; counters frozen and event_in ignored. rd_valid=1 and rd_idx starts at 0.
    - rd_data, rd_ovf and rd_last are stable while rd_valid & !rd_ready.
    - On each handshake rd_idx increments. The handshake with rd_last=1 returns to IDLE next cycle, with rd_valid=0 and rd_idx=0.
- Counter arithmetic (per channel):
  - If lower==FFFF_FFFF: lower becomes 0 and upper increments. Otherwise only lower increments.
  - Increment from all-ones 64-bit wraps to 0 and sets ovf[i], which stays sticky until CLEAR or reset.
- Counters accumulate across successive runs; only CLEAR or reset zeroes them.
- Latency: command accepted at edge k → state change visible at k+1. An event sampled at edge k → count visible at k+1.
- cmd_ready is combinational from state only. No output depends combinationally on event_in.

Test Plan:
1. Reset, CLEAR, then START W=10 with event_in=4'b0101 held high → window_done pulses once. Readout gives ch0=10, ch1=0, ch2=10, ch3=0; rd_last on idx 3; then back to IDLE.
2. START W=0, events on ch1 for 7 cycles, STOP accepted while ch1 is high → readout ch1=8. Hold rd_ready=0 for 5 cycles on idx 1 → rd_data stays 8, rd_idx stays 1.
3. Preload via long run so ch0 lower=FFFF_FFFF, upper=0, then one event → ch0 reads 0x0000_0001_0000_0000. Separately, from all-ones plus one event → ch0 reads 0 with rd_ovf=1; CLEAR → rd_ovf=0 in next dump.
4. In RUN, issue START and CLEAR → cmd_err pulses each time and counts are unchanged. In IDLE, issue STOP → cmd_err pulses. In DUMP, cmd_ready=0.
5. Assert rst=0 asynchronously mid-DUMP between clock edges → rd_valid and running drop before the next edge. After release, state is IDLE and a dump shows all zeros.
6. Two back-to-back START W=3 runs with no CLEAR and ch2 always active → first dump ch2=3, second dump ch2=6.
